// File: rtl/psum_pack_pkg.sv
// psum_pack_pkg
// Shared definitions for the partial-sum stream packer:
//   - layer operation encodings (OP_CONV allows an all-zero terminal word)
//   - packer FSM state enum
//   - elaboration-time helpers for slot count and pointer widths
package psum_pack_pkg;

    localparam logic [1:0] OP_CONV    = 2'd0;
    localparam logic [1:0] OP_FC      = 2'd1;
    localparam logic [1:0] OP_POOL    = 2'd2;
    localparam logic [1:0] OP_ELTWISE = 2'd3;

    typedef enum logic {
        FILL       = 1'b0,
        FLUSH_WAIT = 1'b1
    } pack_state_e;

    // Number of element slots in one output word.
    function automatic int elems_of(input int tdata_w, input int elem_w);
        return tdata_w / elem_w;
    endfunction

    // ceil(log2(v)) but never below 1, so pointers always have at least one bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/psum_pack_fifo.sv
// psum_pack_fifo
// Small synchronous output FIFO with first-word fall-through: a word written
// on a clock edge is visible on pop_data immediately after that edge.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request and word (ignored when full, unless popping)
//   pop                 read request (ignored when empty)
//   pop_data            head word, forced to zero while empty
//   full, empty, count  occupancy status
module psum_pack_fifo
    import psum_pack_pkg::*;
#(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic [W-1:0]                     push_data,
    input  logic                             pop,
    output logic [W-1:0]                     pop_data,
    output logic                             full,
    output logic                             empty,
    output logic [clog2_min1(DEPTH):0]       count
);

    localparam int AW = clog2_min1(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_q];

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/psum_stream_packer.sv
// psum_stream_packer
// Packs narrow per-element partial-sum results into TDATA_W-bit AXI4-Stream
// words. A word closes when its slots are full, at the end of an output row,
// or on layer_finish (which also marks the word with tlast).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   operation                   layer mode; OP_CONV emits a zero terminal word
//   output_channel_size         elements per output row (0 = no row boundary)
//   layer_finish                single-cycle layer-end pulse
//   in_valid/in_ready/in_data   element input handshake
//   m_axis_*                    packed output stream
//   busy                        assembly, flush or FIFO holds data
// Build option: define PSUM_PACK_MSB_FIRST_EN to fill slots from the top down
// (partial words left-aligned); otherwise slots fill LSB-first.
module psum_stream_packer
    import psum_pack_pkg::*;
#(
    parameter int TDATA_W    = 32,
    parameter int ELEM_W     = 1,
    parameter int CH_W       = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         operation,
    input  logic [CH_W-1:0]    output_channel_size,
    input  logic               layer_finish,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ELEM_W-1:0]  in_data,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [TDATA_W-1:0] m_axis_tdata,
    output logic               m_axis_tlast,
    output logic               busy
);

    localparam int ELEMS = elems_of(TDATA_W, ELEM_W);
    localparam int PTR_W = clog2_min1(ELEMS);
    localparam int FAW   = clog2_min1(FIFO_DEPTH);

    pack_state_e        state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]    cnt_q, cnt_d;
    logic [TDATA_W-1:0] word_q, word_d;
    logic               last_q, last_d;

    logic               fifo_push;
    logic [TDATA_W:0]   fifo_push_data;
    logic               fifo_pop;
    logic [TDATA_W:0]   fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FAW:0]       fifo_count;

    logic               accept;
    logic               push_ok;
    logic               slot_last;
    logic               row_end;
    logic               close;
    logic [CH_W:0]      cnt_inc;
    logic [PTR_W-1:0]   slot_idx;
    logic [TDATA_W-1:0] word_cur;

    // Conservative: stall the input whenever the FIFO is full, so in_ready
    // never depends on in_valid or on whether this element would close a word.
    assign in_ready = (state_q == FILL) && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign fifo_pop = m_axis_tvalid && m_axis_tready;
    assign push_ok  = !fifo_full || fifo_pop;

    assign cnt_inc   = {1'b0, cnt_q} + {{CH_W{1'b0}}, 1'b1};
    assign slot_last = (ptr_q == PTR_W'(ELEMS - 1));
    assign row_end   = (output_channel_size != '0) &&
                       (cnt_inc == {1'b0, output_channel_size});

`ifdef PSUM_PACK_MSB_FIRST_EN
    assign slot_idx = PTR_W'(ELEMS - 1) - ptr_q;
`else
    assign slot_idx = ptr_q;
`endif

    // Word under assembly including this cycle's element. ptr==0 means the
    // assembly is logically empty, so old contents are dropped there.
    always_comb begin
        word_cur = (ptr_q == '0) ? '0 : word_q;
        if (accept) word_cur[slot_idx*ELEM_W +: ELEM_W] = in_data;
    end

    // An empty assembly only produces a terminal word in conv mode.
    assign close = (state_q == FILL) &&
                   ((accept && (slot_last || row_end)) ||
                    (layer_finish && (accept || (ptr_q != '0) || (operation == OP_CONV))));

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        word_d         = word_q;
        last_d         = last_q;
        fifo_push      = 1'b0;
        fifo_push_data = {last_q, word_q};
        case (state_q)
            FILL: begin
                if (accept) begin
                    ptr_d  = ptr_q + PTR_W'(1);
                    word_d = word_cur;
                    cnt_d  = row_end ? '0 : cnt_inc[CH_W-1:0];
                end
                if (layer_finish) cnt_d = '0;
                if (close) begin
                    ptr_d  = '0;
                    word_d = word_cur;
                    last_d = layer_finish;
                    if (push_ok) begin
                        fifo_push      = 1'b1;
                        fifo_push_data = {layer_finish, word_cur};
                    end else begin
                        state_d = FLUSH_WAIT;
                    end
                end
            end
            FLUSH_WAIT: begin
                if (push_ok) begin
                    fifo_push = 1'b1;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            ptr_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            last_q  <= last_d;
        end
    end

    psum_pack_fifo #(
        .W     (TDATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tlast  = fifo_head[TDATA_W];
    assign m_axis_tdata  = fifo_head[TDATA_W-1:0];
    assign busy          = (ptr_q != '0) || (state_q == FLUSH_WAIT) || !fifo_empty;

endmodule

// File: tb/tb_psum_stream_packer.sv
// tb_psum_stream_packer
// Directed bench with three packer instances (ELEM_W = 1, 4, 8; TDATA_W = 32,
// FIFO_DEPTH = 4). Output words from all instances are captured into one
// queue tagged with the instance number and compared against hand-computed
// values.
module tb_psum_stream_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  operation;
    logic [8:0]  size;
    logic [2:0]  lf;
    logic [2:0]  vld;
    logic [2:0]  tready;
    logic [2:0]  in_ready;
    logic [2:0]  tvalid;
    logic [2:0]  tlast;
    logic [2:0]  busy;
    logic [31:0] tdata [3];
    logic [7:0]  din   [3];

    logic [34:0] mon_q [$];
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    psum_stream_packer #(.TDATA_W(32), .ELEM_W(1), .CH_W(9), .FIFO_DEPTH(4)) u_e1 (
        .clk(clk), .rst_n(rst_n), .operation(operation), .output_channel_size(size),
        .layer_finish(lf[0]), .in_valid(vld[0]), .in_ready(in_ready[0]), .in_data(din[0][0:0]),
        .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]), .m_axis_tdata(tdata[0]),
        .m_axis_tlast(tlast[0]), .busy(busy[0]));

    psum_stream_packer #(.TDATA_W(32), .ELEM_W(4), .CH_W(9), .FIFO_DEPTH(4)) u_e4 (
        .clk(clk), .rst_n(rst_n), .operation(operation), .output_channel_size(size),
        .layer_finish(lf[1]), .in_valid(vld[1]), .in_ready(in_ready[1]), .in_data(din[1][3:0]),
        .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]), .m_axis_tdata(tdata[1]),
        .m_axis_tlast(tlast[1]), .busy(busy[1]));

    psum_stream_packer #(.TDATA_W(32), .ELEM_W(8), .CH_W(9), .FIFO_DEPTH(4)) u_e8 (
        .clk(clk), .rst_n(rst_n), .operation(operation), .output_channel_size(size),
        .layer_finish(lf[2]), .in_valid(vld[2]), .in_ready(in_ready[2]), .in_data(din[2]),
        .m_axis_tvalid(tvalid[2]), .m_axis_tready(tready[2]), .m_axis_tdata(tdata[2]),
        .m_axis_tlast(tlast[2]), .busy(busy[2]));

    // Capture handshakes half a cycle before the edge that completes them.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && tvalid[k] && tready[k]) begin
                mon_q.push_back({k[1:0], tlast[k], tdata[k]});
                $display("word inst=%0d data=%08h last=%0d", k, tdata[k], tlast[k]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic with_lf);
        int n;
        n = 0;
        while (!in_ready[k] && n < 200) begin
            step();
            n++;
        end
        if (!in_ready[k]) check_val("send_ready", 64'(in_ready[k]), 64'd1);
        vld[k] = 1'b1;
        din[k] = d;
        lf[k]  = with_lf;
        step();
        vld[k] = 1'b0;
        lf[k]  = 1'b0;
    endtask

    task automatic pulse_lf(input int k);
        lf[k] = 1'b1;
        step();
        lf[k] = 1'b0;
    endtask

    task automatic expect_word(input int k, input logic [31:0] d, input logic l, input string tag);
        int          n;
        logic [34:0] e;
        n = 0;
        while (mon_q.size() == 0 && n < 100) begin
            step();
            n++;
        end
        check_val({tag, "_avail"}, 64'(mon_q.size() != 0), 64'd1);
        if (mon_q.size() != 0) begin
            e = mon_q.pop_front();
            check_val({tag, "_inst"}, 64'(e[34:33]), 64'(k));
            check_val({tag, "_data"}, 64'(e[31:0]), 64'(d));
            check_val({tag, "_last"}, 64'(e[32]), 64'(l));
        end
    endtask

    task automatic expect_quiet(input string tag);
        for (int i = 0; i < 10; i++) step();
        check_val(tag, 64'(mon_q.size()), 64'd0);
        mon_q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        operation = 2'd0;
        size      = 9'd0;
        lf        = '0;
        vld       = '0;
        tready    = 3'b111;
        for (int k = 0; k < 3; k++) din[k] = 8'h00;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        check_val("rst_in_ready", 64'(in_ready), 64'h7);
        check_val("rst_tvalid",   64'(tvalid),   64'h0);
        check_val("rst_tdata",    64'(tdata[2]), 64'h0);
        check_val("rst_tlast",    64'(tlast),    64'h0);
        check_val("rst_busy",     64'(busy),     64'h0);

        // ELEM_W=1, size 40: 32-bit full word, then 8 ones closed by layer end
        operation = 2'd0;
        size      = 9'd40;
        for (int i = 0; i < 40; i++) send(0, 8'h01, (i == 39));
        expect_word(0, 32'hFFFF_FFFF, 1'b0, "e1_w0");
        expect_word(0, 32'h0000_00FF, 1'b1, "e1_w1");
        expect_quiet("e1_extra");

        // ELEM_W=4, size 3: row boundaries close every third element
        size = 9'd3;
        for (int i = 1; i <= 6; i++) send(1, 8'(i), 1'b0);
        expect_word(1, 32'h0000_0321, 1'b0, "e4_w0");
        expect_word(1, 32'h0000_0654, 1'b0, "e4_w1");
        expect_quiet("e4_extra");

        // Empty layer end: zero terminal word only in conv mode
        size      = 9'd0;
        operation = 2'd0;
        pulse_lf(2);
        expect_word(2, 32'h0, 1'b1, "conv_empty");
        operation = 2'd1;
        pulse_lf(2);
        expect_quiet("fc_empty_none");

        // Backpressure: fill the FIFO, then a 5th close has to wait
        operation = 2'd0;
        size      = 9'd1;
        tready[2] = 1'b0;
        send(2, 8'h11, 1'b0);
        send(2, 8'h22, 1'b0);
        send(2, 8'h33, 1'b0);
        send(2, 8'h44, 1'b0);
        check_val("full_in_ready", 64'(in_ready[2]), 64'd0);
        check_val("stall_tvalid",  64'(tvalid[2]),   64'd1);
        pulse_lf(2);
        step();
        check_val("flush_in_ready", 64'(in_ready[2]), 64'd0);
        check_val("flush_busy",     64'(busy[2]),     64'd1);
        check_val("stall_tdata",    64'(tdata[2]),    64'h11);
        tready[2] = 1'b1;
        expect_word(2, 32'h0000_0011, 1'b0, "bp_w0");
        expect_word(2, 32'h0000_0022, 1'b0, "bp_w1");
        expect_word(2, 32'h0000_0033, 1'b0, "bp_w2");
        expect_word(2, 32'h0000_0044, 1'b0, "bp_w3");
        expect_word(2, 32'h0000_0000, 1'b1, "bp_w4");
        expect_quiet("bp_extra");

        // Layer end together with the 3rd element
        operation = 2'd1;
        size      = 9'd0;
        send(2, 8'hAA, 1'b0);
        send(2, 8'hBB, 1'b0);
        send(2, 8'hCC, 1'b1);
        expect_word(2, 32'h00CC_BBAA, 1'b1, "lf_same");
        expect_quiet("lf_extra");

        // Reset mid-row discards the partial word
        send(2, 8'hDD, 1'b0);
        send(2, 8'hEE, 1'b0);
        check_val("mid_busy", 64'(busy[2]), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("mrst_in_ready", 64'(in_ready[2]), 64'd1);
        check_val("mrst_tvalid",   64'(tvalid[2]),   64'd0);
        check_val("mrst_busy",     64'(busy[2]),     64'd0);
        step();
        rst_n = 1'b1;
        step();
        send(2, 8'h12, 1'b1);
        expect_word(2, 32'h0000_0012, 1'b1, "post_rst");
        expect_quiet("post_rst_extra");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
